// File: rtl/alsu_if.sv
// ---------------------------------------------------------------------------
// alsu_if : request/response bundle of the pipelined ALSU.
//
// Handshake: valid-only, no ready. A request is accepted on every rising
// clk edge where in_valid=1; the DUT cannot stall. A response is present
// for exactly the one cycle where out_valid=1; the consumer must take it.
//
// Signals (master = request source / response sink, slave = ALSU):
//   in_valid, A, B, opcode, cin, serial_in, direction,
//   red_op_A, red_op_B, bypass_A, bypass_B   master -> slave
//   out, out_valid, invalid, leds            slave  -> master
// ---------------------------------------------------------------------------
interface alsu_if #(
    parameter int WIDTH = 3,
    parameter int LED_W = 16
);
    logic               in_valid;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         opcode;
    logic               cin;
    logic               serial_in;
    logic               direction;
    logic               red_op_A;
    logic               red_op_B;
    logic               bypass_A;
    logic               bypass_B;
    logic [2*WIDTH-1:0] out;
    logic               out_valid;
    logic               invalid;
    logic [LED_W-1:0]   leds;

    modport master (
        output in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B,
        input  out, out_valid, invalid, leds
    );

    modport slave (
        input  in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B,
        output out, out_valid, invalid, leds
    );
endinterface

// File: rtl/alsu_pipe.sv
// ---------------------------------------------------------------------------
// alsu_pipe : two-stage pipelined ALSU with invalid-request detection and
// an error state machine driving a blinking LED bank.
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst      synchronous active-high reset
//   bus_if   alsu_if.slave request/response bundle (see alsu_if.sv)
//   state_o  error FSM state (0 IDLE, 1 RUN, 2 ERR) for observation
//
// Stage 1 captures the request, stage 2 computes and registers the result,
// so a request sampled at edge N appears after edge N+1.
// ---------------------------------------------------------------------------
module alsu_pipe #(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    alsu_if.slave      bus_if,
    output logic [1:0] state_o
);
    localparam int OUT_W  = 2 * WIDTH;
    localparam bit PRIO_B = (INPUT_PRIORITY == "B");
    localparam bit FA_ON  = (FULL_ADDER == "ON");

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Stage 1 registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             cin_q, serial_q, dir_q;
    logic             red_a_q, red_b_q, byp_a_q, byp_b_q;

    // Stage 2 registers and next-state values
    logic [OUT_W-1:0] out_q, out_d;
    logic             out_valid_q;
    logic             inv_q, inv_d;
    state_t           state_q;
    logic [LED_W-1:0] leds_q;

    logic [WIDTH:0]   sum;
    logic [OUT_W-1:0] prod;
    logic             red_and, red_xor;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cin_q      <= 1'b0;
            serial_q   <= 1'b0;
            dir_q      <= 1'b0;
            red_a_q    <= 1'b0;
            red_b_q    <= 1'b0;
            byp_a_q    <= 1'b0;
            byp_b_q    <= 1'b0;
        end else begin
            s1_valid_q <= bus_if.in_valid;
            if (bus_if.in_valid) begin
                a_q      <= bus_if.A;
                b_q      <= bus_if.B;
                op_q     <= bus_if.opcode;
                cin_q    <= bus_if.cin;
                serial_q <= bus_if.serial_in;
                dir_q    <= bus_if.direction;
                red_a_q  <= bus_if.red_op_A;
                red_b_q  <= bus_if.red_op_B;
                byp_a_q  <= bus_if.bypass_A;
                byp_b_q  <= bus_if.bypass_B;
            end
        end
    end

    assign sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, (FA_ON & cin_q)};
    assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Reduction operand selection; only meaningful when a red_op flag is set.
    always_comb begin
        red_and = PRIO_B ? &b_q : &a_q;
        red_xor = PRIO_B ? ^b_q : ^a_q;
        if (red_a_q && !red_b_q) begin
            red_and = &a_q;
            red_xor = ^a_q;
        end else if (red_b_q && !red_a_q) begin
            red_and = &b_q;
            red_xor = ^b_q;
        end
    end

    always_comb begin
        out_d = out_q;
        inv_d = 1'b0;
        if (byp_a_q || byp_b_q) begin
            // Bypass overrides the opcode and is never flagged invalid.
            if (byp_a_q && byp_b_q)
                out_d = PRIO_B ? {{WIDTH{1'b0}}, b_q} : {{WIDTH{1'b0}}, a_q};
            else if (byp_a_q)
                out_d = {{WIDTH{1'b0}}, a_q};
            else
                out_d = {{WIDTH{1'b0}}, b_q};
        end else begin
            case (op_q)
                3'b000: out_d = (red_a_q || red_b_q) ? {{(OUT_W-1){1'b0}}, red_and}
                                                     : {{WIDTH{1'b0}}, a_q & b_q};
                3'b001: out_d = (red_a_q || red_b_q) ? {{(OUT_W-1){1'b0}}, red_xor}
                                                     : {{WIDTH{1'b0}}, a_q ^ b_q};
                3'b010: out_d = {{(WIDTH-1){1'b0}}, sum};
                3'b011: out_d = prod;
                // Shift and rotate act on the last registered result.
                3'b100: out_d = dir_q ? {out_q[OUT_W-2:0], serial_q}
                                      : {serial_q, out_q[OUT_W-1:1]};
                3'b101: out_d = dir_q ? {out_q[OUT_W-2:0], out_q[OUT_W-1]}
                                      : {out_q[0], out_q[OUT_W-1:1]};
                default: begin
                    out_d = '0;
                    inv_d = 1'b1;
                end
            endcase
            // Reduction flags are only legal with AND/XOR.
            if ((red_a_q || red_b_q) && (op_q[2:1] != 2'b00)) begin
                out_d = '0;
                inv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
            inv_q       <= s1_valid_q & inv_d;
            if (s1_valid_q)
                out_q <= out_d;
        end
    end

    // Error FSM; leds toggle every cycle in ERR regardless of traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            leds_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (s1_valid_q && inv_d) begin
                        state_q <= ST_ERR;
                        leds_q  <= '1;
                    end else if (s1_valid_q) begin
                        state_q <= ST_RUN;
                        leds_q  <= '0;
                    end
                end
                ST_ERR: begin
                    if (s1_valid_q && !inv_d) begin
                        state_q <= ST_RUN;
                        leds_q  <= '0;
                    end else begin
                        leds_q <= ~leds_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    leds_q  <= '0;
                end
            endcase
        end
    end

    assign bus_if.out       = out_q;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.invalid   = inv_q;
    assign bus_if.leds      = leds_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_alsu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alsu_pipe : two DUT instances driven with identical requests.
//   dut_a : INPUT_PRIORITY="A", FULL_ADDER="ON"
//   dut_b : INPUT_PRIORITY="B", FULL_ADDER="OFF"
// Expected {invalid,out} responses are pushed per instance at issue time and
// popped by a monitor whenever that instance shows out_valid.
// ---------------------------------------------------------------------------
module tb_alsu_pipe;
    localparam int WIDTH = 3;
    localparam int LED_W = 16;
    localparam int EW    = 2*WIDTH + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state_a, state_b;

    alsu_if #(.WIDTH(WIDTH), .LED_W(LED_W)) ifa ();
    alsu_if #(.WIDTH(WIDTH), .LED_W(LED_W)) ifb ();

    alsu_pipe #(.WIDTH(WIDTH), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(LED_W))
        dut_a (.clk(clk), .rst(rst), .bus_if(ifa), .state_o(state_a));
    alsu_pipe #(.WIDTH(WIDTH), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .LED_W(LED_W))
        dut_b (.clk(clk), .rst(rst), .bus_if(ifb), .state_o(state_b));

    // clock / reset
    always #5 clk = ~clk;

    logic [EW-1:0] exp_a_q[$];
    logic [EW-1:0] exp_b_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // driver tasks
    task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] a,
                         input logic [2:0] b, input logic ci, input logic si,
                         input logic dir, input logic ra, input logic rb,
                         input logic ba, input logic bb);
        ifa.in_valid = v;   ifb.in_valid = v;
        ifa.opcode = op;    ifb.opcode = op;
        ifa.A = a;          ifb.A = a;
        ifa.B = b;          ifb.B = b;
        ifa.cin = ci;       ifb.cin = ci;
        ifa.serial_in = si; ifb.serial_in = si;
        ifa.direction = dir; ifb.direction = dir;
        ifa.red_op_A = ra;  ifb.red_op_A = ra;
        ifa.red_op_B = rb;  ifb.red_op_B = rb;
        ifa.bypass_A = ba;  ifb.bypass_A = ba;
        ifa.bypass_B = bb;  ifb.bypass_B = bb;
    endtask

    // Issue one request in the cycle after the current edge, push expected.
    task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic ci, input logic si, input logic dir,
                         input logic ra, input logic rb, input logic ba, input logic bb,
                         input logic [EW-1:0] ea, input logic [EW-1:0] eb);
        drive(1'b1, op, a, b, ci, si, dir, ra, rb, ba, bb);
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 3'b000, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (ifa.out_valid) begin
            if (exp_a_q.size() == 0) chk("a_unexpected_out_valid", 32'd1, 32'd0);
            else chk("a_resp", {25'd0, ifa.invalid, ifa.out}, {25'd0, exp_a_q.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (ifb.out_valid) begin
            if (exp_b_q.size() == 0) chk("b_unexpected_out_valid", 32'd1, 32'd0);
            else chk("b_resp", {25'd0, ifb.invalid, ifb.out}, {25'd0, exp_b_q.pop_front()});
        end
    end

    initial begin
        drive(1'b0, 3'b000, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out", {26'd0, ifa.out}, 32'd0);
        chk("rst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
        chk("rst_leds", {16'd0, ifa.leds}, 32'd0);
        chk("rst_state", {30'd0, state_a}, 32'd0);

        // op       A  B  ci si d  ra rb ba bb   exp_a        exp_b
        issue(3'b010, 3, 5, 1, 0, 0, 0, 0, 0, 0, {1'b0, 6'd9},  {1'b0, 6'd8});
        issue(3'b010, 7, 7, 1, 0, 0, 0, 0, 0, 0, {1'b0, 6'd15}, {1'b0, 6'd14});
        issue(3'b011, 7, 7, 0, 0, 0, 0, 0, 0, 0, {1'b0, 6'd49}, {1'b0, 6'd49});
        issue(3'b000, 7, 3, 0, 0, 0, 1, 1, 0, 0, {1'b0, 6'd1},  {1'b0, 6'd0});
        issue(3'b000, 6, 3, 0, 0, 0, 0, 0, 0, 0, {1'b0, 6'd2},  {1'b0, 6'd2});
        issue(3'b001, 7, 0, 0, 0, 0, 1, 0, 0, 0, {1'b0, 6'd1},  {1'b0, 6'd1});
        issue(3'b001, 5, 3, 0, 0, 0, 0, 0, 0, 0, {1'b0, 6'd6},  {1'b0, 6'd6});
        issue(3'b011, 1, 1, 0, 0, 0, 1, 0, 0, 0, {1'b1, 6'd0},  {1'b1, 6'd0});
        // shift/rotate chain starting from out=1
        issue(3'b000, 1, 0, 0, 0, 0, 0, 0, 1, 0, {1'b0, 6'd1},  {1'b0, 6'd1});
        issue(3'b100, 0, 0, 0, 1, 1, 0, 0, 0, 0, {1'b0, 6'b000011}, {1'b0, 6'b000011});
        issue(3'b101, 0, 0, 0, 0, 0, 0, 0, 0, 0, {1'b0, 6'b100001}, {1'b0, 6'b100001});
        issue(3'b101, 0, 0, 0, 0, 1, 0, 0, 0, 0, {1'b0, 6'b000011}, {1'b0, 6'b000011});
        issue(3'b100, 0, 0, 0, 1, 0, 0, 0, 0, 0, {1'b0, 6'b100001}, {1'b0, 6'b100001});
        // bypass
        issue(3'b000, 2, 6, 0, 0, 0, 0, 0, 1, 1, {1'b0, 6'd2},  {1'b0, 6'd6});
        issue(3'b000, 0, 5, 0, 0, 0, 0, 0, 0, 1, {1'b0, 6'd5},  {1'b0, 6'd5});
        issue(3'b110, 4, 0, 0, 0, 0, 0, 0, 1, 0, {1'b0, 6'd4},  {1'b0, 6'd4});
        idle(3);
        chk("run_state", {30'd0, state_a}, 32'd1);
        chk("run_leds", {16'd0, ifa.leds}, 32'd0);

        // error FSM: two invalids back-to-back, then recovery
        issue(3'b110, 1, 1, 0, 0, 0, 0, 0, 0, 0, {1'b1, 6'd0}, {1'b1, 6'd0});
        issue(3'b111, 1, 1, 0, 0, 0, 0, 0, 0, 0, {1'b1, 6'd0}, {1'b1, 6'd0});
        chk("err_entry_state", {30'd0, state_a}, 32'd2);
        chk("err_entry_leds", {16'd0, ifa.leds}, 32'h0000FFFF);
        idle(1);
        chk("err_stay_state", {30'd0, state_b}, 32'd2);
        chk("err_toggle0_leds", {16'd0, ifb.leds}, 32'h00000000);
        idle(1);
        chk("err_toggle1_leds", {16'd0, ifa.leds}, 32'h0000FFFF);
        issue(3'b011, 2, 3, 0, 0, 0, 0, 0, 0, 0, {1'b0, 6'd6}, {1'b0, 6'd6});
        idle(1);
        chk("err_exit_state", {30'd0, state_a}, 32'd1);
        chk("err_exit_leds", {16'd0, ifa.leds}, 32'd0);
        idle(2);

        // reset with a request in flight and another offered during reset
        drive(1'b1, 3'b011, 3'd7, 3'd7, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b1, 3'b010, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 3'b000, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_flight_out", {26'd0, ifa.out}, 32'd0);
        chk("rst_flight_valid", {31'd0, ifa.out_valid}, 32'd0);
        chk("rst_flight_state", {30'd0, state_a}, 32'd0);
        @(posedge clk); #1;
        chk("rst_drop_valid", {30'd0, ifa.out_valid, ifb.out_valid}, 32'd0);

        // 3-request burst after release
        issue(3'b010, 1, 1, 0, 0, 0, 0, 0, 0, 0, {1'b0, 6'd2}, {1'b0, 6'd2});
        issue(3'b011, 3, 2, 0, 0, 0, 0, 0, 0, 0, {1'b0, 6'd6}, {1'b0, 6'd6});
        issue(3'b001, 1, 2, 0, 0, 0, 0, 0, 0, 0, {1'b0, 6'd3}, {1'b0, 6'd3});
        idle(1);

        for (int i = 0; i < 20 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        chk("drain_a", exp_a_q.size(), 32'd0);
        chk("drain_b", exp_b_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
